// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants and helpers for the pipelined lookahead ALU (alu_pipe).
//   SLICE_W            : width of one carry-lookahead slice
//   S_ADD..S_OR        : common 74181-style function selects
//   MODE_LOGIC/ARITH   : values of the M mode input
//   alu_f()            : per-bit function generator f = F(S, a, b)
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int SLICE_W = 4;

   localparam logic [3:0] S_ADD = 4'b1010;
   localparam logic [3:0] S_SUB = 4'b0101;
   localparam logic [3:0] S_XOR = 4'b0110;
   localparam logic [3:0] S_AND = 4'b1000;
   localparam logic [3:0] S_OR  = 4'b1110;

   localparam logic MODE_LOGIC = 1'b1;
   localparam logic MODE_ARITH = 1'b0;

   // Sum-of-minterms select: S3 picks a&b, S2 a&!b, S1 !a&b, S0 !a&!b.
   function automatic logic [SLICE_W-1:0] alu_f(input logic [SLICE_W-1:0] a,
                                                input logic [SLICE_W-1:0] b,
                                                input logic [3:0]         s);
      alu_f = ({SLICE_W{s[3]}} &  a &  b)
            | ({SLICE_W{s[2]}} &  a & ~b)
            | ({SLICE_W{s[1]}} & ~a &  b)
            | ({SLICE_W{s[0]}} & ~a & ~b);
   endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// ---------------------------------------------------------------------------
// alu_pipe_if
// Operand and result channels of alu_pipe, each with a valid/ready handshake.
//   in_valid/in_ready          : operand beat handshake
//   a, b, S, M, cin            : operands, function select, mode, carry in
//   out_valid/out_ready        : result beat handshake
//   dout, co, V, Z, N          : result, carry out, overflow, zero, negative
// master: operand-fetch / writeback side; slave: the ALU.
// ---------------------------------------------------------------------------
interface alu_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       S;
   logic             M;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dout;
   logic             co;
   logic             V;
   logic             Z;
   logic             N;

   modport master (
      output in_valid, a, b, S, M, cin, out_ready,
      input  in_ready, out_valid, dout, co, V, Z, N
   );

   modport slave (
      input  in_valid, a, b, S, M, cin, out_ready,
      output in_ready, out_valid, dout, co, V, Z, N
   );
endinterface

// File: rtl/alu_cla_slice.sv
// ---------------------------------------------------------------------------
// alu_cla_slice
// Combinational 4-bit 74181-style slice with internal carry lookahead.
//   i_a, i_b : operand nibbles        i_s   : function select
//   i_m      : mode (1 logic, 0 arith) i_cin : carry into bit 0
//   o_do     : result nibble          o_cout: carry out of bit 3
//   o_c3     : carry into bit 3       o_g/o_p: slice generate / propagate
// In logic mode all carries, G and P are forced to 0.
// ---------------------------------------------------------------------------
module alu_cla_slice
   import alu_pkg::*;
(
   input  logic [SLICE_W-1:0] i_a,
   input  logic [SLICE_W-1:0] i_b,
   input  logic [3:0]         i_s,
   input  logic               i_m,
   input  logic               i_cin,
   output logic [SLICE_W-1:0] o_do,
   output logic               o_cout,
   output logic               o_c3,
   output logic               o_g,
   output logic               o_p
);
   logic               w_arith;
   logic [SLICE_W-1:0] w_f;
   logic [SLICE_W-1:0] w_g;
   logic [SLICE_W-1:0] w_p;
   logic               w_c0;
   logic               w_c1;
   logic               w_c2;
   logic               w_c3;

   assign w_arith = (i_m == MODE_ARITH);
   assign w_f     = alu_f(i_a, i_b, i_s);

   // The second adder operand is f, so g/p are formed from a and f.
   assign w_g  = i_a & w_f & {SLICE_W{w_arith}};
   assign w_p  = (i_a ^ w_f) & {SLICE_W{w_arith}};
   assign w_c0 = i_cin & w_arith;

   // Flat lookahead terms; each carry depends only on g/p and c0.
   assign w_c1 = w_g[0] | (w_p[0] & w_c0);
   assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c0);
   assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & w_c0);

   assign o_g    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign o_p    = &w_p;
   assign o_cout = o_g | (o_p & w_c0);
   assign o_c3   = w_c3;
   assign o_do   = w_arith ? (w_p ^ {w_c3, w_c2, w_c1, w_c0}) : w_f;

endmodule

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
// N-bit 74181-style ALU with a pipelined carry chain. Slice group k (of
// SLICES_PER_STAGE 4-bit slices) is evaluated in stage k; each stage
// register holds the result bits produced so far, the group carry-out, the
// operands still to be consumed, S, M and valid. One output register stage
// follows, so a beat accepted at edge t is presented after edge t+LAT.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : alu_pipe_if.slave (operand and result handshakes)
// Stall (out_valid & !out_ready) freezes every register; in_ready = !stall.
// Optional: define ALU_PIPE_SAT_EN to clamp arithmetic overflow results to
// the most positive / most negative value in the output stage.
// ---------------------------------------------------------------------------
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH            = 16,
   parameter int SLICES_PER_STAGE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_pipe_if.slave  bus
);
   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int SPS    = SLICES_PER_STAGE;
   localparam int LAT    = NSLICE / SPS;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] res;
      logic             c;    // carry out of the last evaluated group
      logic             cm;   // carry into the top bit of that group
      logic [3:0]       s;
      logic             m;
      logic             v;
   } stage_t;

   stage_t             w_src [LAT];
   stage_t             w_nxt [LAT];
   stage_t             r_pipe [LAT];
   logic [LAT-1:0]     w_gcin;
   logic [NSLICE-1:0]  w_cin;
   logic [NSLICE-1:0]  w_sg;
   logic [NSLICE-1:0]  w_sp;
   logic [NSLICE-1:0]  w_scout;
   logic [NSLICE-1:0]  w_sc3;
   logic [SLICE_W-1:0] w_sdo [NSLICE];

   logic               w_stall;
   logic [WIDTH-1:0]   w_dout;
   logic               w_co;
   logic               w_v;
   logic               w_z;
   logic               w_n;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_dout;
   logic               r_co;
   logic               r_v;
   logic               r_z;
   logic               r_n;

   // Stage inputs: fresh operands for stage 0, the previous register otherwise.
   for (genvar k = 0; k < LAT; k++) begin : g_src
      if (k == 0) begin : g_first
         assign w_src[k]  = '{a: bus.a, b: bus.b, res: '0, c: 1'b0, cm: 1'b0,
                              s: bus.S, m: bus.M, v: bus.in_valid};
         assign w_gcin[k] = bus.cin & (bus.M == MODE_ARITH);
      end else begin : g_next
         assign w_src[k]  = r_pipe[k-1];
         assign w_gcin[k] = r_pipe[k-1].c;
      end
   end

   for (genvar j = 0; j < NSLICE; j++) begin : g_slice
      localparam int K = j / SPS;
      alu_cla_slice u_slice (
         .i_a    (w_src[K].a[j*SLICE_W +: SLICE_W]),
         .i_b    (w_src[K].b[j*SLICE_W +: SLICE_W]),
         .i_s    (w_src[K].s),
         .i_m    (w_src[K].m),
         .i_cin  (w_cin[j]),
         .o_do   (w_sdo[j]),
         .o_cout (w_scout[j]),
         .o_c3   (w_sc3[j]),
         .o_g    (w_sg[j]),
         .o_p    (w_sp[j])
      );
   end

   // Group lookahead: carry into each slice from the stage carry-in and lower slice G/P.
   always_comb begin
      logic v_c;
      v_c   = 1'b0;
      w_cin = '0;
      for (int k = 0; k < LAT; k++) begin
         v_c = w_gcin[k];
         for (int o = 0; o < SPS; o++) begin
            w_cin[k*SPS+o] = v_c;
            v_c = w_sg[k*SPS+o] | (w_sp[k*SPS+o] & v_c);
         end
      end
   end

   // Next stage contents: pass operands along and merge this group's result bits.
   always_comb begin
      for (int k = 0; k < LAT; k++) begin
         w_nxt[k] = w_src[k];
         for (int o = 0; o < SPS; o++) begin
            w_nxt[k].res[(k*SPS+o)*SLICE_W +: SLICE_W] = w_sdo[k*SPS+o];
         end
         w_nxt[k].c  = w_scout[k*SPS+SPS-1];
         w_nxt[k].cm = w_sc3[k*SPS+SPS-1];
      end
   end

   // Output stage: flags (and optional clamp) on the fully assembled result.
   always_comb begin
      w_co   = r_pipe[LAT-1].c;
      w_v    = (r_pipe[LAT-1].m == MODE_ARITH) & (r_pipe[LAT-1].c ^ r_pipe[LAT-1].cm);
      w_dout = r_pipe[LAT-1].res;
`ifdef ALU_PIPE_SAT_EN
      // Overflow implies both addends share a's sign, which picks the clamp.
      if (w_v) begin
         if (r_pipe[LAT-1].a[WIDTH-1]) begin
            w_dout = {1'b1, {(WIDTH-1){1'b0}}};
         end else begin
            w_dout = {1'b0, {(WIDTH-1){1'b1}}};
         end
      end else begin
         w_dout = r_pipe[LAT-1].res;
      end
`endif
      w_z = (w_dout == {WIDTH{1'b0}});
      w_n = w_dout[WIDTH-1];
   end

   assign w_stall      = r_out_valid & ~bus.out_ready;
   assign bus.in_ready = ~w_stall;

   // Pipeline advance: all stages and the output register move together unless stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < LAT; k++) begin
            r_pipe[k] <= '0;
         end
         r_out_valid <= 1'b0;
         r_dout      <= '0;
         r_co        <= 1'b0;
         r_v         <= 1'b0;
         r_z         <= 1'b0;
         r_n         <= 1'b0;
      end else if (!w_stall) begin
         for (int k = 0; k < LAT; k++) begin
            r_pipe[k] <= w_nxt[k];
         end
         r_out_valid <= r_pipe[LAT-1].v;
         r_dout      <= w_dout;
         r_co        <= w_co;
         r_v         <= w_v;
         r_z         <= w_z;
         r_n         <= w_n;
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.dout      = r_dout;
   assign bus.co        = r_co;
   assign bus.V         = r_v;
   assign bus.Z         = r_z;
   assign bus.N         = r_n;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor of the 4-bit lookahead ALU slice family.
- N-bit, 74181-style function-select ALU, built from 4-bit carry-lookahead slices.
- Carry chain is pipelined: a register boundary after every SLICES_PER_STAGE slices, with operand skew and result deskew.
- Valid/ready handshake on input and output; sits between the operand-fetch stage and writeback in the datapath.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4.
- SLICES_PER_STAGE, 1, 4-bit slices evaluated per pipeline stage; must divide WIDTH/4.
- Derived: NSLICE = WIDTH/4; LAT = NSLICE/SLICES_PER_STAGE (pipeline depth in cycles).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- S  in  4  function select.
- M  in  1  mode: 1 = logic, 0 = arithmetic.
- cin  in  1  carry in (ignored when M=1).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- do  out  WIDTH  result.
- co  out  1  carry out of MSB.
- V  out  1  signed overflow.
- Z  out  1  result equals zero.
- N  out  1  result MSB.

Behaviour:
- Reset: one clock, reset is synchronous and active-low (clk, rst_n). While rst_n=0 at a rising edge, all stage valid bits, do, co, V, Z, N and out_valid are cleared to 0. In-flight beats are discarded, with no partial output. in_ready=1 from the first cycle after reset.
- Per-bit function: f_i = S3·a_i·b_i + S2·a_i·!b_i + S1·!a_i·b_i + S0·!a_i·!b_i.
- Logic mode (M=1):
  - do = f (bitwise); carries are forced to 0.
  - co=0, V=0.
- Arithmetic mode (M=0):
  - do = (a + f + cin) mod 2^WIDTH, with f as the second operand.
  - Examples: ADD is S=1010, cin=0; SUB is S=0101, cin=1; INC is S=0000, cin=1; DEC is S=1111, cin=0.
  - Flags: co = c[WIDTH]; V = c[WIDTH] ^ c[WIDTH-1].
- Z = (do == 0) and N = do[WIDTH-1], both computed on the final output value.
- Carry within a stage uses slice generate/propagate lookahead. A registered carry passes between stages.
- Stage k registers:
  - its result bits;
  - the carry out of slice group k;
  - the not-yet-consumed upper operand bits;
  - S, M and valid.
- Lower result bits are delayed so all bits of a beat emerge together.
- Latency: a beat accepted (in_valid & in_ready) at edge t appears with out_valid=1 after edge t+LAT.
- Throughput: 1 beat/cycle.
- Stall: stall = out_valid & !out_ready.
  - in_ready = !stall.
  - While stalled, every stage register, including out regs, holds.
  - No bubble collapsing.
- Bubble: a stage with valid=0 still advances when not stalled. Its data content is don't-care.
- Simultaneous accept and output consume in the same cycle are legal, with no bubble inserted.
- Outputs are stable while out_valid=1 and out_ready=0.
- Beats stay in order; no loss, no duplication.

Optional Feature:
- Macro ALU_PIPE_SAT_EN.
- Defined: in arithmetic mode, when overflow occurs, do is clamped in the output stage to 0111…1 (positive overflow, a MSB=0) or 1000…0 (negative overflow). V still reports 1, co is unchanged, and Z/N are taken from the clamped value.
- Undefined: the result wraps modulo 2^WIDTH. Logic mode is unaffected either way.

Decomposition:
- Package alu_pkg:
  - SLICE_W=4;
  - op constants S_ADD=4'b1010, S_SUB=4'b0101, S_XOR=4'b0110, S_AND=4'b1000, S_OR=4'b1110;
  - MODE_LOGIC=1'b1, MODE_ARITH=1'b0.
- Sub-module alu_cla_slice: combinational 4-bit slice.
  - Inputs: a, b, S, M, cin.
  - Outputs: do[3:0], cout, c3 (carry into bit 3, for V).
  - alu_pipe instantiates NSLICE of these.

Test Plan (WIDTH=16, SLICES_PER_STAGE=1, LAT=4):
- ADD: a=0x7FFF, b=0x0001, S=1010, M=0, cin=0 → after 4 cycles do=0x8000, V=1, co=0, N=1, Z=0.
- SUB: a=0x0005, b=0x0005, S=0101, M=0, cin=1 → do=0x0000, Z=1, co=1, V=0, N=0.
- XOR: a=0xF0F0, b=0xFF00, S=0110, M=1, cin=1 → do=0x0FF0, co=0, V=0, Z=0.
- Backpressure: 8 back-to-back ADDs, out_ready=0 for 3 cycles mid-stream → in_ready=0 during the stall, outputs held, all 8 results delivered in order, none lost or duplicated.
- Reset mid-flight: rst_n=0 for 1 cycle with 3 beats in flight → out_valid=0 and do=0 next cycle, no stale result afterwards, in_ready=1.
- With ALU_PIPE_SAT_EN: 0x7FFF+0x0001 → do=0x7FFF, V=1; 0x8000−0x0001 → do=0x8000, V=1. Without the macro, the second case gives do=0x7FFF, V=1.
